// File: rtl/keypad_multich_entry_if.sv
// Commit-update handshake between the keypad entry block and its downstream consumer.
// The master side offers {upd_ch, upd_bcd} with upd_valid; the slave accepts with upd_ready.
interface keypad_multich_entry_if #(
  parameter int N_DIGITS = 7,
  parameter int N_CH     = 2
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                    upd_valid;
  logic                    upd_ready;
  logic [CH_W-1:0]         upd_ch;
  logic [4*N_DIGITS-1:0]   upd_bcd;

  modport master (
    output upd_valid,
    output upd_ch,
    output upd_bcd,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_ch,
    input  upd_bcd,
    output upd_ready
  );
endinterface

// File: rtl/keypad_multich_entry.sv
// Multi-channel BCD keypad entry: one-shot press detection, digit edit buffer,
// per-channel mode toggles and a valid/ready commit port for confirmed values.
module keypad_multich_entry #(
  parameter int          N_DIGITS = 7,
  parameter int          N_CH     = 2,
  parameter logic [31:0] MAX_BCD  = 32'h0500_0000,
  localparam int         CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int         DC_W     = $clog2(N_DIGITS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                key_code,
  input  logic                       key_valid,
  output logic [4*N_DIGITS-1:0]      edit_bcd,
  output logic [DC_W-1:0]            digit_count,
  output logic [CH_W-1:0]            active_ch,
  output logic [3*N_CH-1:0]          mode_flags,
  output logic [4*N_DIGITS*N_CH-1:0] committed_bcd,
  keypad_multich_entry_if.master     upd,
  output logic                       err_full,
  output logic                       err_range,
  output logic                       ch_changed
);

  localparam int              BW      = 4 * N_DIGITS;
  localparam logic [BW-1:0]   MAX_LIM = MAX_BCD[BW-1:0];
  localparam logic [DC_W-1:0] FULL    = DC_W'(N_DIGITS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  typedef enum logic {
    ARMED,
    HELD
  } press_state_t;

  press_state_t    state;
  logic            upd_valid_q;
  logic [CH_W-1:0] upd_ch_q;
  logic [BW-1:0]   upd_bcd_q;

  assign upd.upd_valid = upd_valid_q;
  assign upd.upd_ch    = upd_ch_q;
  assign upd.upd_bcd   = upd_bcd_q;

  logic          single_key;
  logic          fire;
  logic          is_digit;
  logic [3:0]    key_digit;
  logic [CH_W-1:0] next_ch;
  logic [BW-1:0] next_committed;

  assign single_key = $onehot(key_code);
  assign fire       = key_valid && single_key && (state == ARMED);

  // Digit keys: bit 15 is '1' down to bit 7 is '9'; bit 6 is '0'.
  always_comb begin
    is_digit  = 1'b0;
    key_digit = 4'd0;
    for (int i = 7; i < 16; i++) begin
      if (key_code[i]) begin
        is_digit  = 1'b1;
        key_digit = 4'(16 - i);
      end
    end
    if (key_code[6]) begin
      is_digit  = 1'b1;
      key_digit = 4'd0;
    end
  end

  always_comb begin
    next_ch        = (active_ch == LAST_CH) ? '0 : active_ch + CH_W'(1);
    next_committed = committed_bcd[int'(next_ch)*BW +: BW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HELD;
      edit_bcd      <= '0;
      digit_count   <= '0;
      active_ch     <= '0;
      mode_flags    <= '0;
      committed_bcd <= '0;
      upd_valid_q   <= 1'b0;
      upd_ch_q      <= '0;
      upd_bcd_q     <= '0;
      err_full      <= 1'b0;
      err_range     <= 1'b0;
      ch_changed    <= 1'b0;
    end else begin
      err_full   <= 1'b0;
      err_range  <= 1'b0;
      ch_changed <= 1'b0;

      if (upd_valid_q && upd.upd_ready) begin
        upd_valid_q <= 1'b0;
      end

      if (key_valid) begin
        if (key_code == 16'd0) begin
          state <= ARMED;
        end else if (single_key && state == ARMED) begin
          state <= HELD;
        end
      end

      if (fire) begin
        if (is_digit) begin
          if (digit_count < FULL) begin
            edit_bcd    <= {edit_bcd[BW-5:0], key_digit};
            digit_count <= digit_count + DC_W'(1);
          end else begin
            err_full <= 1'b1;
          end
        end else if (key_code[5]) begin
          mode_flags[int'(active_ch)*3 + 0] <= ~mode_flags[int'(active_ch)*3 + 0];
        end else if (key_code[4]) begin
          mode_flags[int'(active_ch)*3 + 1] <= ~mode_flags[int'(active_ch)*3 + 1];
        end else if (key_code[3]) begin
          mode_flags[int'(active_ch)*3 + 2] <= ~mode_flags[int'(active_ch)*3 + 2];
        end else if (key_code[2]) begin
          // A single-channel build has nothing to switch to, so only the pulse is produced.
          if (N_CH > 1) begin
            active_ch   <= next_ch;
            edit_bcd    <= next_committed;
            digit_count <= FULL;
          end
          ch_changed <= 1'b1;
        end else if (key_code[1]) begin
          if (digit_count != '0) begin
            edit_bcd    <= {4'd0, edit_bcd[BW-1:4]};
            digit_count <= digit_count - DC_W'(1);
          end
        end else if (key_code[0]) begin
          // A confirm while an update is still pending is dropped, not queued.
          if (!upd_valid_q) begin
            if (edit_bcd > MAX_LIM) begin
              err_range <= 1'b1;
            end else begin
              committed_bcd[int'(active_ch)*BW +: BW] <= edit_bcd;
              upd_ch_q    <= active_ch;
              upd_bcd_q   <= edit_bcd;
              upd_valid_q <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_multich_entry.sv
// Directed bench for keypad_multich_entry; commit updates are checked through a
// scoreboard queue filled at confirm time and drained on each accepted handshake.
module tb_keypad_multich_entry;

  localparam int N_DIGITS = 7;
  localparam int N_CH     = 2;
  localparam int BW       = 4 * N_DIGITS;
  localparam int CH_W     = 1;
  localparam int DC_W     = 3;

  localparam logic [15:0] K_A     = 16'h0020;
  localparam logic [15:0] K_B     = 16'h0010;
  localparam logic [15:0] K_C     = 16'h0008;
  localparam logic [15:0] K_NEXT  = 16'h0004;
  localparam logic [15:0] K_ERASE = 16'h0002;
  localparam logic [15:0] K_CONF  = 16'h0001;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [15:0]          key_code = 16'd0;
  logic                 key_valid = 1'b0;
  logic                 upd_ready = 1'b0;
  logic [BW-1:0]        edit_bcd;
  logic [DC_W-1:0]      digit_count;
  logic [CH_W-1:0]      active_ch;
  logic [3*N_CH-1:0]    mode_flags;
  logic [BW*N_CH-1:0]   committed_bcd;
  logic                 err_full;
  logic                 err_range;
  logic                 ch_changed;

  int tests = 0;
  int fails = 0;
  logic [CH_W+BW-1:0] sb[$];

  keypad_multich_entry_if #(.N_DIGITS(N_DIGITS), .N_CH(N_CH)) upd ();
  assign upd.upd_ready = upd_ready;

  keypad_multich_entry #(
    .N_DIGITS(N_DIGITS),
    .N_CH    (N_CH),
    .MAX_BCD (32'h0500_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .edit_bcd     (edit_bcd),
    .digit_count  (digit_count),
    .active_ch    (active_ch),
    .mode_flags   (mode_flags),
    .committed_bcd(committed_bcd),
    .upd          (upd.master),
    .err_full     (err_full),
    .err_range    (err_range),
    .ch_changed   (ch_changed)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dkey(input int d);
    if (d == 0) return 16'h0040;
    return 16'h0001 << (16 - d);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sampling edge per call: drive at the falling edge, return just after the rising edge.
  task automatic applyStimulus(input logic [15:0] code, input logic valid);
    @(negedge clk);
    key_code  = code;
    key_valid = valid;
    @(posedge clk);
    #1;
  endtask

  task automatic tapKey(input logic [15:0] code);
    applyStimulus(code, 1'b1);
    applyStimulus(16'd0, 1'b1);
  endtask

  task automatic enterNumber(input logic [BW-1:0] v);
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      tapKey(dkey(int'(v[4*i +: 4])));
    end
  endtask

  task automatic clearEdit();
    repeat (N_DIGITS) tapKey(K_ERASE);
  endtask

  always @(posedge clk) begin
    if (!rst && upd.upd_valid && upd.upd_ready) begin
      checkOutput("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        logic [CH_W+BW-1:0] e;
        e = sb.pop_front();
        checkOutput("sb_ch", 64'(upd.upd_ch), 64'(e[CH_W+BW-1:BW]));
        checkOutput("sb_bcd", 64'(upd.upd_bcd), 64'(e[BW-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    key_code  = dkey(5);
    key_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_edit", 64'(edit_bcd), 64'd0);
    checkOutput("rst_count", 64'(digit_count), 64'd0);
    checkOutput("rst_ch", 64'(active_ch), 64'd0);
    checkOutput("rst_mode", 64'(mode_flags), 64'd0);
    checkOutput("rst_commit", 64'(committed_bcd), 64'd0);
    checkOutput("rst_valid", 64'(upd.upd_valid), 64'd0);

    rst = 1'b0;
    applyStimulus(dkey(5), 1'b1);
    applyStimulus(dkey(5), 1'b1);
    checkOutput("held_after_rst_edit", 64'(edit_bcd), 64'd0);
    checkOutput("held_after_rst_count", 64'(digit_count), 64'd0);
    applyStimulus(16'd0, 1'b1);

    tapKey(dkey(1));
    tapKey(dkey(2));
    tapKey(dkey(3));
    checkOutput("enter123_edit", 64'(edit_bcd), 64'h123);
    checkOutput("enter123_count", 64'(digit_count), 64'd3);

    applyStimulus(16'h0003, 1'b1);
    applyStimulus(16'h0003, 1'b1);
    checkOutput("multibit_edit", 64'(edit_bcd), 64'h123);
    applyStimulus(16'd0, 1'b1);

    applyStimulus(dkey(4), 1'b1);
    applyStimulus(dkey(4), 1'b1);
    applyStimulus(dkey(4), 1'b1);
    checkOutput("hold_once_edit", 64'(edit_bcd), 64'h1234);
    checkOutput("hold_once_count", 64'(digit_count), 64'd4);
    applyStimulus(16'd0, 1'b1);

    tapKey(dkey(5));
    tapKey(dkey(6));
    tapKey(dkey(7));
    applyStimulus(dkey(8), 1'b1);
    checkOutput("full_err", 64'(err_full), 64'd1);
    checkOutput("full_edit", 64'(edit_bcd), 64'h1234567);
    checkOutput("full_count", 64'(digit_count), 64'd7);
    applyStimulus(16'd0, 1'b1);
    checkOutput("full_err_pulse", 64'(err_full), 64'd0);

    tapKey(K_ERASE);
    checkOutput("erase_edit", 64'(edit_bcd), 64'h0123456);
    checkOutput("erase_count", 64'(digit_count), 64'd6);
    repeat (6) tapKey(K_ERASE);
    checkOutput("erase_all_edit", 64'(edit_bcd), 64'd0);
    tapKey(K_ERASE);
    checkOutput("erase_empty_count", 64'(digit_count), 64'd0);

    enterNumber(28'h6000000);
    applyStimulus(K_CONF, 1'b1);
    checkOutput("range_err", 64'(err_range), 64'd1);
    checkOutput("range_valid", 64'(upd.upd_valid), 64'd0);
    applyStimulus(16'd0, 1'b1);
    checkOutput("range_err_pulse", 64'(err_range), 64'd0);

    clearEdit();
    enterNumber(28'h4999999);
    upd_ready = 1'b0;
    applyStimulus(K_CONF, 1'b1);
    sb.push_back({1'b0, 28'h4999999});
    checkOutput("conf_valid", 64'(upd.upd_valid), 64'd1);
    checkOutput("conf_bcd", 64'(upd.upd_bcd), 64'h4999999);
    checkOutput("conf_ch", 64'(upd.upd_ch), 64'd0);
    applyStimulus(16'd0, 1'b1);

    tapKey(K_ERASE);
    checkOutput("busy_erase_edit", 64'(edit_bcd), 64'h0499999);
    applyStimulus(K_CONF, 1'b1);
    checkOutput("busy_conf_bcd", 64'(upd.upd_bcd), 64'h4999999);
    checkOutput("busy_conf_commit", 64'(committed_bcd), 64'h4999999);
    checkOutput("busy_conf_valid", 64'(upd.upd_valid), 64'd1);
    applyStimulus(16'd0, 1'b1);
    tapKey(dkey(9));
    checkOutput("busy_digit_edit", 64'(edit_bcd), 64'h4999999);

    upd_ready = 1'b1;
    applyStimulus(16'd0, 1'b1);
    checkOutput("hs_valid_low", 64'(upd.upd_valid), 64'd0);
    checkOutput("hs_commit", 64'(committed_bcd), 64'h0000000_4999999);
    upd_ready = 1'b0;

    applyStimulus(K_NEXT, 1'b1);
    checkOutput("next1_ch", 64'(active_ch), 64'd1);
    checkOutput("next1_pulse", 64'(ch_changed), 64'd1);
    checkOutput("next1_edit", 64'(edit_bcd), 64'd0);
    checkOutput("next1_count", 64'(digit_count), 64'd7);
    applyStimulus(16'd0, 1'b1);
    checkOutput("next1_pulse_end", 64'(ch_changed), 64'd0);
    tapKey(K_B);
    checkOutput("toggle_b_ch1", 64'(mode_flags), 64'b010_000);
    applyStimulus(K_NEXT, 1'b1);
    checkOutput("next0_ch", 64'(active_ch), 64'd0);
    checkOutput("next0_pulse", 64'(ch_changed), 64'd1);
    checkOutput("next0_edit", 64'(edit_bcd), 64'h4999999);
    applyStimulus(16'd0, 1'b1);
    tapKey(K_C);
    checkOutput("toggle_c_ch0", 64'(mode_flags), 64'b010_100);
    tapKey(K_A);
    tapKey(K_A);
    checkOutput("toggle_a_twice", 64'(mode_flags), 64'b010_100);

    tapKey(K_NEXT);
    clearEdit();
    enterNumber(28'h5000000);
    upd_ready = 1'b1;
    applyStimulus(K_CONF, 1'b1);
    sb.push_back({1'b1, 28'h5000000});
    checkOutput("max_valid", 64'(upd.upd_valid), 64'd1);
    checkOutput("max_err", 64'(err_range), 64'd0);
    checkOutput("max_ch", 64'(upd.upd_ch), 64'd1);
    applyStimulus(16'd0, 1'b1);
    checkOutput("max_hs_valid", 64'(upd.upd_valid), 64'd0);
    checkOutput("max_commit", 64'(committed_bcd), 64'h5000000_4999999);

    upd_ready = 1'b0;
    applyStimulus(K_CONF, 1'b1);
    checkOutput("pend_valid", 64'(upd.upd_valid), 64'd1);
    rst = 1'b1;
    applyStimulus(16'd0, 1'b0);
    checkOutput("rst_pend_valid", 64'(upd.upd_valid), 64'd0);
    checkOutput("rst_pend_commit", 64'(committed_bcd), 64'd0);
    checkOutput("rst_pend_mode", 64'(mode_flags), 64'd0);
    checkOutput("rst_pend_ch", 64'(active_ch), 64'd0);
    rst = 1'b0;
    applyStimulus(16'd0, 1'b0);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_multich_entry.md
KEYPAD_MULTICH_ENTRY -- requirements
Module: keypad_multich_entry

Interface
REQ-001 Parameter N_DIGITS, default 7: number of BCD digits in the edit buffer (range 2..8).
REQ-002 Parameter N_CH, default 2: number of output channels (range 1..8); CH_W = max(1, clog2(N_CH)).
REQ-003 Parameter MAX_BCD, 32 bits, default 32'h0500_0000: highest committable value; only bits [4*N_DIGITS-1:0] are used.
REQ-004 Ports and synchronisation:
- clk, in, 1: the only clock.
- rst, in, 1: reset, synchronous and active-high.
- key_code, in, 16: one-hot key image. Bits 15..7 are digits 1..9, bit 6 is digit 0, bits 5/4/3 are toggles A/B/C, bit 2 is next-channel, bit 1 is erase, bit 0 is confirm.
- key_valid, in, 1: key_code is qualified this cycle.
- edit_bcd, out, 4*N_DIGITS: edit buffer, least significant digit in [3:0].
- digit_count, out, clog2(N_DIGITS+1): number of digits entered.
- active_ch, out, CH_W: channel being edited.
- mode_flags, out, 3*N_CH: per-channel {C,B,A} toggles; channel k occupies [3k+2:3k].
- committed_bcd, out, 4*N_DIGITS*N_CH: committed value per channel; channel k occupies slice k.
- upd_valid, out, 1: commit update offered downstream.
- upd_ready, in, 1: downstream accepts the update.
- upd_ch, out, CH_W: channel of the offered update.
- upd_bcd, out, 4*N_DIGITS: value of the offered update.
- err_full, out, 1: one-cycle pulse, digit rejected.
- err_range, out, 1: one-cycle pulse, confirm rejected.
- ch_changed, out, 1: one-cycle pulse on a channel switch.

Function
REQ-005 The press detector SHALL have two states, ARMED and HELD.
- ARMED -> HELD on key_valid with exactly one key_code bit set; that key is executed in the same cycle.
- HELD -> ARMED on key_valid with key_code == 0.
- All other inputs leave the state unchanged and execute nothing.
- A multi-bit key_code is ignored in both states.
REQ-006 Digit key with digit_count < N_DIGITS: shift edit_bcd left one digit, insert the digit at [3:0], increment digit_count. Outputs update on the cycle after the press.
REQ-007 Digit key with digit_count == N_DIGITS: edit_bcd and digit_count are unchanged; err_full pulses for 1 cycle.
REQ-008 Erase with digit_count > 0: shift edit_bcd right one digit, clear the most significant digit, decrement digit_count. Erase with digit_count == 0 is a no-op.
REQ-009 Toggle A/B/C: invert bit 0/1/2 respectively of the active channel's mode_flags. Other channels are unaffected.
REQ-010 Next-channel: active_ch advances to active_ch+1, wrapping from N_CH-1 to 0.
- edit_bcd loads the new channel's committed_bcd.
- digit_count is set to N_DIGITS.
- ch_changed pulses.
- With N_CH == 1, only ch_changed pulses.
REQ-011 Confirm is evaluated in this order:
- If upd_valid is high, the key is ignored (busy).
- Else if edit_bcd > MAX_BCD (unsigned compare on the packed BCD), err_range pulses and nothing is committed.
- Else committed_bcd[active_ch] <= edit_bcd, upd_ch <= active_ch, upd_bcd <= edit_bcd, upd_valid <= 1. The edit buffer is retained.
REQ-012 upd_valid SHALL stay high, with upd_ch and upd_bcd stable, until a cycle with upd_valid && upd_ready, and SHALL go low on the next cycle.
REQ-013 Digit, erase, toggle and next-channel keys SHALL remain operative while upd_valid is high. They do not alter upd_ch or upd_bcd.
REQ-014 Only key_code values with exactly one bit set are executed. Any key_code value other than the ones listed is a no-op.

Reset
REQ-015 While rst is high, on each clk edge:
- edit_bcd, digit_count, active_ch, mode_flags, committed_bcd, upd_ch, upd_bcd are cleared to 0.
- upd_valid, err_full, err_range, ch_changed are driven to 0.
- The detector state is HELD.
REQ-016 Reset asserted while upd_valid is high SHALL drop upd_valid on the next edge, with no handshake completion required.
REQ-017 The first key SHALL be executed only after a release (key_code == 0 with key_valid) has been seen following reset deassertion.

Verification
REQ-018 Release, then press 1,2,3 with releases between -> edit_bcd[11:0] = 12'h123, digit_count = 3.
REQ-019 Press eight digits with releases between, N_DIGITS = 7 -> the 8th press pulses err_full; edit_bcd is unchanged. One erase -> digit_count = 6 and the most significant digit is 0.
REQ-020 Enter 6000000, confirm -> err_range pulses, upd_valid stays 0. Enter 4999999, confirm with upd_ready = 0 -> upd_valid held with upd_bcd = 28'h4999999. A second confirm is ignored. Raise upd_ready -> upd_valid falls 1 cycle later, committed_bcd slice 0 = 28'h4999999.
REQ-021 Next-channel twice with N_CH = 2 -> active_ch 0 -> 1 -> 0, ch_changed pulses each time, edit_bcd reloads 28'h4999999 on returning to 0. Toggle B on channel 1 -> mode_flags = 6'b010_000.
REQ-022 key_code = 16'h0003 held -> no action. Key held across rst deassertion -> no action until release. rst during a pending update -> upd_valid = 0 on the next edge.
